// File: rtl/binarize_pack.sv
// binarize_pack
//   Turns the per-kernel-position biased popcounts from the XNOR accumulation
//   stage into packed binary activations for the next layer.
//   Per accepted beat (one output channel):
//     stage 1 : strip the MSB bias from each partial popcount, sum them and
//               register the sum together with the channel index
//     stage 2 : compare the sum with that channel's threshold and write the
//               result bit into the pack register; the last channel of a word
//               moves the completed word to word_o
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   acc_i / acc_valid_i /   : KERNEL_SIZE biased popcounts for one channel,
//   acc_ready_o               valid/ready handshake
//   thr_we_i / thr_addr_i / : threshold table write port
//   thr_data_i
//   word_o / word_valid_o / : packed activations (bit i = channel i),
//   word_ready_i              valid/ready handshake
//
// Optional feature macro: THRESH_FLIP_EN
//   When defined, every threshold entry carries a flip bit (MSB of
//   thr_data_i) that inverts the compare to total < thr, for channels with a
//   negative batch-norm gamma. When undefined the compare is always >=.
//
// Parameter defaults come from the KERNEL_SIZE, CHANNEL_CNT and BIT_WIDTH
// macros when those are defined. CHANNEL_CNT must be at least 2.

`ifndef KERNEL_SIZE
`define KERNEL_SIZE 9
`endif
`ifndef CHANNEL_CNT
`define CHANNEL_CNT 64
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module binarize_pack #(
  parameter int KERNEL_SIZE = `KERNEL_SIZE,
  parameter int CHANNEL_CNT = `CHANNEL_CNT,
  parameter int BIT_WIDTH   = `BIT_WIDTH,
  parameter int SUM_WIDTH   = BIT_WIDTH + $clog2(KERNEL_SIZE),
`ifdef THRESH_FLIP_EN
  localparam int THR_WIDTH  = SUM_WIDTH + 1,
`else
  localparam int THR_WIDTH  = SUM_WIDTH,
`endif
  localparam int IDX_WIDTH  = $clog2(CHANNEL_CNT)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [KERNEL_SIZE-1:0][BIT_WIDTH-1:0] acc_i,
  input  logic                                  acc_valid_i,
  output logic                                  acc_ready_o,
  input  logic                                  thr_we_i,
  input  logic [IDX_WIDTH-1:0]                  thr_addr_i,
  input  logic [THR_WIDTH-1:0]                  thr_data_i,
  output logic [CHANNEL_CNT-1:0]                word_o,
  output logic                                  word_valid_o,
  input  logic                                  word_ready_i
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHANNEL_CNT - 1);

  // State
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;          // channel of the next beat
  logic                   s1_valid_q, s1_valid_d;
  logic [SUM_WIDTH-1:0]   s1_total_q, s1_total_d;
  logic [IDX_WIDTH-1:0]   s1_idx_q, s1_idx_d;
  logic [CHANNEL_CNT-1:0] pack_q, pack_d;
  logic [CHANNEL_CNT-1:0] word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic [SUM_WIDTH-1:0]   thr_q [CHANNEL_CNT];
  logic [SUM_WIDTH-1:0]   thr_d [CHANNEL_CNT];
`ifdef THRESH_FLIP_EN
  logic [CHANNEL_CNT-1:0] flip_q, flip_d;
`endif

  // Combinational helpers
  logic [SUM_WIDTH-1:0]   total;
  logic                   unused_bias;
  logic                   s1_last;
  logic                   s1_advance;
  logic                   xfer;
  logic                   thr_ge;
  logic                   act_bit;
  logic [CHANNEL_CNT-1:0] pack_next;

  // Unbias and reduce. Upstream keeps each popcount below 2^(BIT_WIDTH-1),
  // so the MSB is pure bias and the sum fits SUM_WIDTH without overflow.
  always_comb begin
    total       = '0;
    unused_bias = 1'b0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      total       = total + SUM_WIDTH'(acc_i[k][BIT_WIDTH-2:0]);
      unused_bias = unused_bias ^ acc_i[k][BIT_WIDTH-1];
    end
  end

  // Stage 1 may only retire its final channel when the output register is
  // free (or being emptied on this very edge).
  assign s1_last     = (s1_idx_q == LAST_IDX);
  assign s1_advance  = s1_valid_q && !(s1_last && word_valid_q && !word_ready_i);
  assign acc_ready_o = !s1_valid_q || s1_advance;
  assign xfer        = acc_valid_i && acc_ready_o;

  // Compare reads the registered table, so a same-cycle write to the same
  // entry is seen only by later compares.
  always_comb begin
    thr_ge = (s1_total_q >= thr_q[s1_idx_q]);
`ifdef THRESH_FLIP_EN
    act_bit = flip_q[s1_idx_q] ? !thr_ge : thr_ge;
`else
    act_bit = thr_ge;
`endif
  end

  always_comb begin
    idx_d        = idx_q;
    s1_valid_d   = s1_valid_q && !s1_advance;
    s1_total_d   = s1_total_q;
    s1_idx_d     = s1_idx_q;
    pack_d       = pack_q;
    pack_next    = pack_q;
    word_d       = word_q;
    word_valid_d = word_valid_q && !word_ready_i;
    thr_d        = thr_q;
`ifdef THRESH_FLIP_EN
    flip_d       = flip_q;
`endif

    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_total_d = total;
      s1_idx_d   = idx_q;
      idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_WIDTH'(1);
    end

    if (s1_advance) begin
      pack_next[s1_idx_q] = act_bit;
      if (s1_last) begin
        // Loading here also covers the accept-and-reload case: valid stays 1.
        word_d       = pack_next;
        word_valid_d = 1'b1;
        pack_d       = '0;
      end else begin
        pack_d = pack_next;
      end
    end

    if (thr_we_i) begin
      thr_d[thr_addr_i] = thr_data_i[SUM_WIDTH-1:0];
`ifdef THRESH_FLIP_EN
      flip_d[thr_addr_i] = thr_data_i[SUM_WIDTH];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_total_q   <= '0;
      s1_idx_q     <= '0;
      pack_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      for (int i = 0; i < CHANNEL_CNT; i++) thr_q[i] <= '0;
`ifdef THRESH_FLIP_EN
      flip_q       <= '0;
`endif
    end else begin
      idx_q        <= idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_total_q   <= s1_total_d;
      s1_idx_q     <= s1_idx_d;
      pack_q       <= pack_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      thr_q        <= thr_d;
`ifdef THRESH_FLIP_EN
      flip_q       <= flip_d;
`endif
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: tb/tb_binarize_pack.sv
// Self-checking bench for binarize_pack (default parameters: 9 x 8-bit
// popcounts, 64 channels, 12-bit sums). Directed vectors with hand-computed
// expectations; a negedge monitor collects accepted words and checks that a
// held word stays stable.
module tb_binarize_pack;
  localparam int KS = 9;
  localparam int CC = 64;
  localparam int BW = 8;
  localparam int SW = 12;
`ifdef THRESH_FLIP_EN
  localparam int TW = SW + 1;
`else
  localparam int TW = SW;
`endif

  typedef logic [KS-1:0][BW-1:0] beat_t;

  typedef struct {
    logic [BW-1:0] b;    // value placed in every acc_i lane
    logic [SW-1:0] thr;  // threshold for that channel
    logic          exp;  // expected activation bit
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  beat_t         acc;
  logic          acc_valid, acc_ready;
  logic          thr_we;
  logic [5:0]    thr_addr;
  logic [TW-1:0] thr_data;
  logic [CC-1:0] word;
  logic          word_valid, word_ready;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [CC-1:0] wq[$];

  always #5 clk = ~clk;

  binarize_pack #(.KERNEL_SIZE(KS), .CHANNEL_CNT(CC), .BIT_WIDTH(BW)) dut (
    .clk_i(clk), .rst_i(rst),
    .acc_i(acc), .acc_valid_i(acc_valid), .acc_ready_o(acc_ready),
    .thr_we_i(thr_we), .thr_addr_i(thr_addr), .thr_data_i(thr_data),
    .word_o(word), .word_valid_o(word_valid), .word_ready_i(word_ready)
  );

  task automatic chk(input string name, input logic [CC-1:0] act, input logic [CC-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Word capture and hold-stability check, sampled on the falling edge.
  logic [CC-1:0] prev_word;
  logic          prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst && prev_hold) begin
      chk("hold_word", word, prev_word);
      chk("hold_valid", CC'(word_valid), CC'(1));
    end
    if (!rst && word_valid && word_ready) wq.push_back(word);
    prev_hold = !rst && word_valid && !word_ready;
    prev_word = word;
  end

  function automatic beat_t uni(input logic [BW-1:0] b);
    beat_t r;
    for (int k = 0; k < KS; k++) r[k] = b;
    return r;
  endfunction

  task automatic send_beat(input beat_t v);
    logic r;
    int   n;
    n = 0;
    acc = v;
    acc_valid = 1'b1;
    do begin
      @(negedge clk); r = acc_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 300);
    if (!r) timeout("beat_accept");
    acc_valid = 1'b0;
  endtask

  task automatic wr_thr(input int a, input logic [TW-1:0] d);
    thr_we = 1'b1; thr_addr = 6'(a); thr_data = d;
    @(posedge clk); #1;
    thr_we = 1'b0;
  endtask

  task automatic wait_words(input int n, input string name);
    int c;
    c = 0;
    while (wq.size() < n && c < 50) begin @(posedge clk); #1; c++; end
    if (wq.size() < n) timeout(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'd160, 12'd288,  1'b1};  // total 288
    tbl[1] = '{8'd160, 12'd289,  1'b0};
    tbl[2] = '{8'd128, 12'd1,    1'b0};  // bias only, total 0
    tbl[3] = '{8'd255, 12'd1,    1'b1};  // total 1143
    tbl[4] = '{8'd255, 12'd1143, 1'b1};
    tbl[5] = '{8'd255, 12'd1144, 1'b0};
    tbl[6] = '{8'd127, 12'd1143, 1'b1};  // no bias bit set, total 1143
    tbl[7] = '{8'd159, 12'd280,  1'b0};  // total 279
    tbl[8] = '{8'd159, 12'd279,  1'b1};

    rst = 1'b1; acc = '0; acc_valid = 1'b0; thr_we = 1'b0; thr_addr = '0;
    thr_data = '0; word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc_ready", CC'(acc_ready), CC'(1));
    chk("rst_word_valid", CC'(word_valid), CC'(0));
    chk("rst_word", word, '0);
    rst = 1'b0;

    // All thresholds 288, total 288 everywhere -> all ones, 2-cycle latency.
    for (int i = 0; i < CC; i++) wr_thr(i, TW'(288));
    for (int i = 0; i < CC; i++) send_beat(uni(8'd160));
    chk("lat_early_valid", CC'(word_valid), CC'(0));
    @(posedge clk); #1;
    chk("lat_valid", CC'(word_valid), CC'(1));
    chk("t1_word", word, {CC{1'b1}});
    @(posedge clk); #1;
    chk("t1_drop_valid", CC'(word_valid), CC'(0));
    chk("t1_count", CC'(wq.size()), CC'(1));
    wq.delete();

    // Even channels 289, odd 288 -> alternating pattern.
    for (int i = 0; i < CC; i++) wr_thr(i, (i % 2 == 0) ? TW'(289) : TW'(288));
    for (int i = 0; i < CC; i++) send_beat(uni(8'd160));
    wait_words(1, "t2_word_wait");
    chk("t2_word", (wq.size() > 0) ? wq[0] : '0, 64'hAAAA_AAAA_AAAA_AAAA);
    wq.delete();

    // Table: channel i < 9 uses tbl[i]; remaining channels total 0 vs thr 0 -> 1.
    for (int i = 0; i < CC; i++) wr_thr(i, (i < 9) ? TW'(tbl[i].thr) : TW'(0));
    for (int i = 0; i < CC; i++) send_beat((i < 9) ? uni(tbl[i].b) : uni(8'd128));
    wait_words(1, "tbl_word_wait");
    if (wq.size() > 0) begin
      for (int i = 0; i < 9; i++)
        chk($sformatf("tbl_bit%0d", i), CC'(wq[0][i]), CC'(tbl[i].exp));
      chk("tbl_upper", wq[0] >> 9, {CC{1'b1}} >> 9);
    end
    wq.delete();

    // Back-pressure: 128 beats back-to-back; word_ready low until stage 1
    // stalls on channel 63 of the second word, then 10 more cycles.
    for (int i = 0; i < CC; i++) wr_thr(i, (i % 2 == 0) ? TW'(289) : TW'(288));
    word_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * CC; i++)
          send_beat((i < CC) ? uni(8'd160) : ((i % 2 == 0) ? uni(8'd255) : uni(8'd128)));
      end
      begin
        int n;
        n = 0;
        while (!word_valid && n < 500) begin @(posedge clk); #1; n++; end
        chk("t4_first_valid", CC'(word_valid), CC'(1));
        chk("t4_first_word", word, 64'hAAAA_AAAA_AAAA_AAAA);
        n = 0;
        while (acc_ready && n < 500) begin @(posedge clk); #1; n++; end
        chk("t4_ready_drop", CC'(acc_ready), CC'(0));
        repeat (10) begin
          @(posedge clk); #1;
          chk("t4_ready_low", CC'(acc_ready), CC'(0));
        end
        word_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_reload_valid", CC'(word_valid), CC'(1));
        chk("t4_reload_word", word, 64'h5555_5555_5555_5555);
        chk("t4_ready_back", CC'(acc_ready), CC'(1));
      end
    join
    wait_words(2, "t4_word_wait");
    chk("t4_count", CC'(wq.size()), CC'(2));
    chk("t4_word1", (wq.size() > 0) ? wq[0] : '0, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t4_word2", (wq.size() > 1) ? wq[1] : '0, 64'h5555_5555_5555_5555);
    wq.delete();

    // Reset mid-word: 30 beats discarded, thresholds back to 0.
    for (int i = 0; i < 30; i++) send_beat(uni(8'd160));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_acc_ready", CC'(acc_ready), CC'(1));
    chk("t5_rst_valid", CC'(word_valid), CC'(0));
    chk("t5_rst_word", word, '0);
    for (int i = 0; i < CC; i++) send_beat(uni(8'd128));
    repeat (5) @(posedge clk);
    #1;
    chk("t5_count", CC'(wq.size()), CC'(1));
    chk("t5_word", (wq.size() > 0) ? wq[0] : '0, {CC{1'b1}});
    wq.delete();

`ifdef THRESH_FLIP_EN
    // Channel 5 flipped at 288: total 288 -> 0, total 287 -> 1.
    wr_thr(5, {1'b1, 12'd288});
    for (int i = 0; i < CC; i++) send_beat(uni(8'd160));
    wait_words(1, "flip_a_wait");
    chk("flip_eq", (wq.size() > 0) ? wq[0] : '0, ~(64'h1 << 5));
    wq.delete();
    for (int i = 0; i < CC; i++) begin
      beat_t v;
      v = uni(8'd160);
      if (i == 5) v[0] = 8'd159;
      send_beat(v);
    end
    wait_words(1, "flip_b_wait");
    chk("flip_below", (wq.size() > 0) ? wq[0] : '0, {CC{1'b1}});
    wq.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
